// File: rtl/snake_pkg.sv
// Shared snake-game constants: PS/2 scan codes, direction encoding used by control,
// and the scan-code lookups used by the keyboard decoder.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic hit;
        dir_e dir;
    } key_hit_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    // Arrow codes are only meaningful after an E0 prefix; the caller qualifies that.
    function automatic key_hit_t arrow_lookup(input logic [7:0] code);
        key_hit_t k;
        k.hit = 1'b1;
        k.dir = DIR_LEFT;
        case (code)
            SC_LEFT:  k.dir = DIR_LEFT;
            SC_RIGHT: k.dir = DIR_RIGHT;
            SC_DOWN:  k.dir = DIR_DOWN;
            SC_UP:    k.dir = DIR_UP;
            default:  k.hit = 1'b0;
        endcase
        return k;
    endfunction

    function automatic key_hit_t letter_lookup(input logic [7:0] code);
        key_hit_t k;
        k.hit = 1'b1;
        k.dir = DIR_LEFT;
        case (code)
            SC_A:    k.dir = DIR_LEFT;
            SC_D:    k.dir = DIR_RIGHT;
            SC_S:    k.dir = DIR_DOWN;
            SC_W:    k.dir = DIR_UP;
            default: k.hit = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM with
// odd-parity/stop checking and an inter-edge timeout that aborts partial frames.
module ps2_rx_frame
    import snake_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    ck_sync;
    logic [1:0]    dt_sync;
    logic          fall;
    logic          dat;
    rx_state_e     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic [TW-1:0] to_cnt;

    assign fall = ck_sync[2] & ~ck_sync[1];
    assign dat  = dt_sync[1];

    // Sync flops reset to the idle-high line level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ck_sync <= 3'b111;
            dt_sync <= 2'b11;
        end else begin
            ck_sync <= {ck_sync[1:0], ps2_clk};
            dt_sync <= {dt_sync[0], ps2_dat};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            to_cnt     <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;

            // Timeout can only fire in a non-edge cycle, so it never races the FSM below.
            if (state == RX_IDLE || fall) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
                state     <= RX_IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    RX_IDLE: begin
                        if (!dat) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {dat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        parity <= dat;
                        state  <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (dat && (^{shreg, parity})) begin
                            scan_code  <= shreg;
                            scan_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_direction_keys.sv
// PS/2 keyboard front end: make/break decoder producing held-direction levels.
// Define PS2_WASD_EN to also map W/A/S/D alongside the extended arrow keys.
module ps2_direction_keys
    import snake_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       mv_left,
    output logic       mv_right,
    output logic       mv_down,
    output logic       mv_up,
    output logic       any_key,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic       ext;
    logic       brk;
    logic [3:0] arrow_q;
    logic [3:0] mv;
    key_hit_t   hit_a;

    ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    assign hit_a = arrow_lookup(scan_code);

`ifdef PS2_WASD_EN
    // Letter and arrow holds are kept apart so releasing one leaves the other held.
    logic [3:0] letter_q;
    key_hit_t   hit_l;
    assign hit_l = letter_lookup(scan_code);
    assign mv    = arrow_q | letter_q;
`else
    assign mv    = arrow_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            arrow_q <= '0;
`ifdef PS2_WASD_EN
            letter_q <= '0;
`endif
        end else if (scan_valid) begin
            case (scan_code)
                SC_EXT:   ext <= 1'b1;
                SC_BREAK: brk <= 1'b1;
                default: begin
                    if (ext && hit_a.hit) arrow_q[hit_a.dir] <= ~brk;
`ifdef PS2_WASD_EN
                    if (!ext && hit_l.hit) letter_q[hit_l.dir] <= ~brk;
`endif
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) any_key <= 1'b0;
        else         any_key <= |mv;
    end

    assign mv_left  = mv[DIR_LEFT];
    assign mv_right = mv[DIR_RIGHT];
    assign mv_down  = mv[DIR_DOWN];
    assign mv_up    = mv[DIR_UP];

endmodule

// File: tb/tb_ps2_direction_keys.sv
// Self-checking bench for ps2_direction_keys: table vectors, timing/corner sequences,
// and random scan-code streams checked against a key-hold reference model.
module tb_ps2_direction_keys;

    localparam int TO = 400;
    localparam int HP = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       mv_left, mv_right, mv_down, mv_up, any_key;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;

    ps2_direction_keys #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .mv_left    (mv_left),
        .mv_right   (mv_right),
        .mv_down    (mv_down),
        .mv_up      (mv_up),
        .any_key    (any_key),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse counters and edge timestamps, sampled on the falling clk edge.
    int cyc = 0, sv_cnt = 0, err_cnt = 0, last_sv = 0, l_rise = -1, a_rise = -1;
    bit prev_l = 0, prev_a = 0, both_seen = 0;
    always @(negedge clk) begin
        cyc++;
        if (scan_valid) begin sv_cnt++; last_sv = cyc; end
        if (frame_err) err_cnt++;
        if (scan_valid && frame_err) both_seen = 1;
        if (mv_left && !prev_l) l_rise = cyc;
        if (any_key && !prev_a) a_rise = cyc;
        prev_l = mv_left;
        prev_a = any_key;
    end

    // Reference model: held state per (source, direction) keyed by {ext, byte}.
    int         keymap[int];
    bit         m_held[2][4];
    bit         m_ext, m_brk;
    logic [7:0] m_code;

    function automatic logic [3:0] m_mv();
        logic [3:0] v;
        for (int d = 0; d < 4; d++) v[d] = m_held[0][d] | m_held[1][d];
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) for (int d = 0; d < 4; d++) m_held[s][d] = 0;
        m_ext = 0; m_brk = 0; m_code = 8'h00;
    endtask

    task automatic model_apply(input logic [7:0] b);
        int k;
        m_code = b;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            k = (m_ext ? 256 : 0) + int'(b);
            if (keymap.exists(k)) m_held[m_ext ? 0 : 1][keymap[k]] = !m_brk;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            repeat (HP) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HP) @(posedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HP) @(posedge clk);
        ps2_dat = 1'b1;
    endtask

    int d_sv, d_err;
    task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int sv0, err0;
        sv0 = sv_cnt; err0 = err_cnt;
        send_bits(b, bad_par, bad_stop, 11);
        repeat (8) @(posedge clk);
        @(negedge clk);
        d_sv = sv_cnt - sv0; d_err = err_cnt - err0;
        if (!bad_par && !bad_stop) model_apply(b);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".mv"},   int'({mv_up, mv_down, mv_right, mv_left}), int'(m_mv()));
        check({tag, ".any"},  int'(any_key), int'(|m_mv()));
        check({tag, ".code"}, int'(scan_code), int'(m_code));
    endtask

    typedef struct {
        logic [7:0] b;
        bit         bad;
        logic [3:0] mv;
        logic [7:0] code;
        int         nsv;
        int         nerr;
    } vec_t;
    vec_t tbl[19];

    logic [7:0] pool[12];

    initial begin
        keymap[256 + 8'h6B] = 0; keymap[256 + 8'h74] = 1;
        keymap[256 + 8'h72] = 2; keymap[256 + 8'h75] = 3;
`ifdef PS2_WASD_EN
        keymap[8'h1C] = 0; keymap[8'h23] = 1; keymap[8'h1B] = 2; keymap[8'h1D] = 3;
`endif
        model_reset();

        tbl[0]  = '{8'h12, 0, 4'b0000, 8'h12, 1, 0};
        tbl[1]  = '{8'hE0, 0, 4'b0000, 8'hE0, 1, 0};
        tbl[2]  = '{8'h6B, 0, 4'b0001, 8'h6B, 1, 0};
        tbl[3]  = '{8'hE0, 0, 4'b0001, 8'hE0, 1, 0};
        tbl[4]  = '{8'hF0, 0, 4'b0001, 8'hF0, 1, 0};
        tbl[5]  = '{8'h6B, 0, 4'b0000, 8'h6B, 1, 0};
        tbl[6]  = '{8'hE0, 0, 4'b0000, 8'hE0, 1, 0};
        tbl[7]  = '{8'h75, 1, 4'b0000, 8'hE0, 0, 1};
        tbl[8]  = '{8'hAA, 0, 4'b0000, 8'hAA, 1, 0};
        tbl[9]  = '{8'hE0, 0, 4'b0000, 8'hE0, 1, 0};
        tbl[10] = '{8'h74, 0, 4'b0010, 8'h74, 1, 0};
        tbl[11] = '{8'hE0, 0, 4'b0010, 8'hE0, 1, 0};
        tbl[12] = '{8'h6B, 0, 4'b0011, 8'h6B, 1, 0};
        tbl[13] = '{8'hE0, 0, 4'b0011, 8'hE0, 1, 0};
        tbl[14] = '{8'hF0, 0, 4'b0011, 8'hF0, 1, 0};
        tbl[15] = '{8'h74, 0, 4'b0001, 8'h74, 1, 0};
        tbl[16] = '{8'hE0, 0, 4'b0001, 8'hE0, 1, 0};
        tbl[17] = '{8'hF0, 0, 4'b0001, 8'hF0, 1, 0};
        tbl[18] = '{8'h6B, 0, 4'b0000, 8'h6B, 1, 0};

        pool = '{8'hE0, 8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75,
                 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hAA};

        resetn = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              int'({mv_left, mv_right, mv_down, mv_up, any_key, scan_code, scan_valid, frame_err}), 0);
        resetn = 1'b1;
        repeat (5) @(posedge clk);

        // Single good frame 0x1C, then release it in case it maps to a letter.
        do_frame(8'h1C, 0, 0);
        check("1c.code", int'(scan_code), 8'h1C);
        check("1c.nsv", d_sv, 1);
        check("1c.nerr", d_err, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h1C, 0, 0);
        check_model("1c_release");

        // Cycle-exact latency: scan_valid -> mv_left -> any_key.
        do_frame(8'hE0, 0, 0);
        do_frame(8'h6B, 0, 0);
        check("lat.mv_after_sv", l_rise - last_sv, 1);
        check("lat.any_after_mv", a_rise - l_rise, 1);
        check_model("left_make");
        do_frame(8'hE0, 0, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h6B, 0, 0);
        check_model("left_break");

        foreach (tbl[i]) begin
            do_frame(tbl[i].b, tbl[i].bad, 1'b0);
            check($sformatf("tbl%0d.mv", i), int'({mv_up, mv_down, mv_right, mv_left}), int'(tbl[i].mv));
            check($sformatf("tbl%0d.any", i), int'(any_key), int'(|tbl[i].mv));
            check($sformatf("tbl%0d.code", i), int'(scan_code), int'(tbl[i].code));
            check($sformatf("tbl%0d.nsv", i), d_sv, tbl[i].nsv);
            check($sformatf("tbl%0d.nerr", i), d_err, tbl[i].nerr);
        end
        // The parity-failed 75 left E0 pending in the model; the table's AA consumed it.
        check_model("after_table");

        // Abandon a frame after 5 bits; the timeout must abort it.
        begin
            int sv0, err0;
            sv0 = sv_cnt; err0 = err_cnt;
            send_bits(8'h72, 0, 0, 5);
            repeat (TO + 40) @(posedge clk);
            @(negedge clk);
            check("timeout.nerr", err_cnt - err0, 1);
            check("timeout.nsv", sv_cnt - sv0, 0);
        end
        do_frame(8'h72, 0, 0);
        check("after_to.code", int'(scan_code), 8'h72);
        check("after_to.nsv", d_sv, 1);

`ifdef PS2_WASD_EN
        do_frame(8'h1D, 0, 0);
        check("wasd.w_up", int'(mv_up), 1);
        do_frame(8'hE0, 0, 0); do_frame(8'h75, 0, 0);
        do_frame(8'hF0, 0, 0); do_frame(8'h1D, 0, 0);
        check("wasd.arrow_holds", int'(mv_up), 1);
        do_frame(8'hE0, 0, 0); do_frame(8'hF0, 0, 0); do_frame(8'h75, 0, 0);
        check("wasd.released", int'(mv_up), 0);
        check_model("wasd");
`endif

        // Hold right+left, then reset mid-frame.
        do_frame(8'hE0, 0, 0); do_frame(8'h74, 0, 0);
        do_frame(8'hE0, 0, 0); do_frame(8'h6B, 0, 0);
        check("both.right", int'(mv_right), 1);
        check("both.left", int'(mv_left), 1);
        send_bits(8'h5A, 0, 0, 4);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midreset_outputs",
              int'({mv_left, mv_right, mv_down, mv_up, any_key, scan_code, scan_valid, frame_err}), 0);
        model_reset();
        repeat (5) @(posedge clk);
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        do_frame(8'hE0, 0, 0);
        do_frame(8'h75, 0, 0);
        check("postreset.nsv", d_sv, 1);
        check_model("postreset");

        // Random streams, including occasional parity and stop errors.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit bp, bs;
            b  = pool[$urandom_range(11, 0)];
            bp = ($urandom_range(9, 0) == 0);
            bs = !bp && ($urandom_range(14, 0) == 0);
            do_frame(b, bp, bs);
            check_model($sformatf("rnd%0d", n));
            check($sformatf("rnd%0d.nsv", n), d_sv, (bp || bs) ? 0 : 1);
            check($sformatf("rnd%0d.nerr", n), d_err, (bp || bs) ? 1 : 0);
        end

        check("sv_err_overlap", int'(both_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
